// File: rtl/vend_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vend_pkg                                                        |
// | Brief    : Shared command/fault encodings and dispenser state type.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package vend_pkg;

    localparam logic [1:0] CMD_NONE     = 2'b00;
    localparam logic [1:0] CMD_PROD     = 2'b10;
    localparam logic [1:0] CMD_PROD_CHG = 2'b11;
    localparam logic [1:0] CMD_CHG      = 2'b01;

    localparam logic [1:0] FAULT_NONE   = 2'b00;
    localparam logic [1:0] FAULT_NODROP = 2'b01;
    localparam logic [1:0] FAULT_NOCOIN = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MOTOR     = 3'd1,
        ST_WAIT_DROP = 3'd2,
        ST_HOPPER    = 3'd3,
        ST_WAIT_COIN = 3'd4,
        ST_DONE      = 3'd5,
        ST_FAULT     = 3'd6
    } dispense_state_t;

    function automatic logic cmd_has_product(input logic [1:0] c);
        return (c == CMD_PROD) || (c == CMD_PROD_CHG);
    endfunction

    function automatic logic cmd_has_change(input logic [1:0] c);
        return (c == CMD_PROD_CHG) || (c == CMD_CHG);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vend_timer                                                      |
// | Brief    : Saturating loadable up-counter with clear and terminal compare. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module vend_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_count;

    // clr marks the first cycle of a new interval: the count reads as zero
    // this cycle, so the compare sees elapsed cycles without a one-cycle lag.
    assign w_count = clr ? '0 : r_cnt;
    assign tc      = (w_count == limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (w_count != '1) begin
            r_cnt <= w_count + CNT_W'(1);
        end else begin
            r_cnt <= w_count;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vend_dispenser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vend_dispenser                                                  |
// | Brief    : Motor/hopper actuator responder with sensor confirmation,       |
// |            one-deep command slot and fault reporting.                      |
// |            Option macro VEND_RETRY_EN: one motor retry on drop timeout.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module vend_dispenser #(
    parameter int MOTOR_CYCLES  = 8,
    parameter int DROP_TIMEOUT  = 32,
    parameter int HOPPER_CYCLES = 4,
    parameter int COIN_TIMEOUT  = 16,
    parameter int CNT_W         = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cmd,
    input  logic       item_sensed,
    input  logic       coin_sensed,
    input  logic       fault_clr,
    output logic       motor_on,
    output logic       hopper_on,
    output logic       busy,
    output logic       vend_done,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic       overrun
);

    import vend_pkg::*;

    dispense_state_t  r_state;
    logic [1:0]       r_cmd;
    logic [1:0]       r_pend_cmd;
    logic [1:0]       r_fault_code;
    logic             r_pend_vld;
    logic             r_overrun;
    logic             r_drop;
    logic             r_coin;
    logic             r_enter;

    logic             w_req;
    logic             w_pop;
    logic [1:0]       w_launch;
    logic             w_drop;
    logic             w_coin;
    logic             w_tc;
    logic             w_retry_ok;
    logic [CNT_W-1:0] w_limit;

    assign w_req  = (cmd != CMD_NONE);
    assign w_pop  = r_pend_vld && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    // A queued command always goes first; a live cmd only launches from IDLE.
    assign w_launch = r_pend_vld ? r_pend_cmd :
                      ((r_state == ST_IDLE) ? cmd : CMD_NONE);
    assign w_drop = r_drop | item_sensed;
    assign w_coin = r_coin | coin_sensed;

    always_comb begin
        w_limit = '1;
        case (r_state)
            ST_MOTOR:     w_limit = CNT_W'(MOTOR_CYCLES - 1);
            ST_WAIT_DROP: w_limit = CNT_W'(DROP_TIMEOUT - 1);
            ST_HOPPER:    w_limit = CNT_W'(HOPPER_CYCLES - 1);
            ST_WAIT_COIN: w_limit = CNT_W'(COIN_TIMEOUT - 1);
            default:      ;
        endcase
    end

    vend_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (r_enter),
        .load     (1'b0),
        .load_val ('0),
        .limit    (w_limit),
        .tc       (w_tc)
    );

`ifdef VEND_RETRY_EN
    logic r_retry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retry <= 1'b0;
        end else if ((r_state == ST_DONE) || (r_state == ST_FAULT)) begin
            r_retry <= 1'b0;
        end else if ((r_state == ST_WAIT_DROP) && !w_drop && w_tc) begin
            r_retry <= 1'b1;
        end
    end

    assign w_retry_ok = !r_retry;
`else
    assign w_retry_ok = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_enter      <= 1'b0;
            r_cmd        <= CMD_NONE;
            r_pend_cmd   <= CMD_NONE;
            r_pend_vld   <= 1'b0;
            r_fault_code <= FAULT_NONE;
            r_overrun    <= 1'b0;
            r_drop       <= 1'b0;
            r_coin       <= 1'b0;
        end else begin
            r_enter <= 1'b0;
            if ((r_state == ST_MOTOR) && item_sensed) r_drop <= 1'b1;
            if ((r_state == ST_HOPPER) && coin_sensed) r_coin <= 1'b1;

            if (r_state == ST_FAULT) begin
                r_pend_vld <= 1'b0;
            end else if (w_pop) begin
                r_pend_vld <= w_req;
                r_pend_cmd <= cmd;
            end else if ((r_state != ST_IDLE) && w_req) begin
                if (r_pend_vld) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_pend_vld <= 1'b1;
                    r_pend_cmd <= cmd;
                end
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_launch != CMD_NONE) begin
                        r_cmd   <= w_launch;
                        r_drop  <= 1'b0;
                        r_coin  <= 1'b0;
                        r_enter <= 1'b1;
                        r_state <= cmd_has_product(w_launch) ? ST_MOTOR : ST_HOPPER;
                    end else if (r_state == ST_DONE) begin
                        r_enter <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_MOTOR: begin
                    if (w_tc) begin
                        r_enter <= 1'b1;
                        r_state <= ST_WAIT_DROP;
                    end
                end
                ST_WAIT_DROP: begin
                    if (w_drop) begin
                        r_enter <= 1'b1;
                        r_coin  <= 1'b0;
                        r_state <= cmd_has_change(r_cmd) ? ST_HOPPER : ST_DONE;
                    end else if (w_tc) begin
                        r_enter <= 1'b1;
                        if (w_retry_ok) begin
                            r_state <= ST_MOTOR;
                        end else begin
                            r_state      <= ST_FAULT;
                            r_fault_code <= FAULT_NODROP;
                        end
                    end
                end
                ST_HOPPER: begin
                    if (w_tc) begin
                        r_enter <= 1'b1;
                        r_state <= ST_WAIT_COIN;
                    end
                end
                ST_WAIT_COIN: begin
                    if (w_coin) begin
                        r_enter <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (w_tc) begin
                        r_enter      <= 1'b1;
                        r_state      <= ST_FAULT;
                        r_fault_code <= FAULT_NOCOIN;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        r_enter      <= 1'b1;
                        r_state      <= ST_IDLE;
                        r_fault_code <= FAULT_NONE;
                        r_overrun    <= 1'b0;
                    end
                end
                default: begin
                    r_enter <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign motor_on   = (r_state == ST_MOTOR);
    assign hopper_on  = (r_state == ST_HOPPER);
    assign busy       = (r_state != ST_IDLE);
    assign vend_done  = (r_state == ST_DONE);
    assign fault      = (r_state == ST_FAULT);
    assign fault_code = r_fault_code;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_vend_dispenser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vend_dispenser                                               |
// | Brief    : Directed scenarios plus random traffic against a cycle model.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_vend_dispenser;

    localparam int MOTOR_CYCLES  = 8;
    localparam int DROP_TIMEOUT  = 32;
    localparam int HOPPER_CYCLES = 4;
    localparam int COIN_TIMEOUT  = 16;
`ifdef VEND_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    localparam int P_IDLE = 0, P_MOTOR = 1, P_WDROP = 2, P_HOPPER = 3,
                   P_WCOIN = 4, P_DONE = 5, P_FAULT = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic       item_sensed = 1'b0;
    logic       coin_sensed = 1'b0;
    logic       fault_clr = 1'b0;
    logic       motor_on, hopper_on, busy, vend_done, fault, overrun;
    logic [1:0] fault_code;

    vend_dispenser #(
        .MOTOR_CYCLES  (MOTOR_CYCLES),
        .DROP_TIMEOUT  (DROP_TIMEOUT),
        .HOPPER_CYCLES (HOPPER_CYCLES),
        .COIN_TIMEOUT  (COIN_TIMEOUT),
        .CNT_W         (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (cmd),
        .item_sensed (item_sensed),
        .coin_sensed (coin_sensed),
        .fault_clr   (fault_clr),
        .motor_on    (motor_on),
        .hopper_on   (hopper_on),
        .busy        (busy),
        .vend_done   (vend_done),
        .fault       (fault),
        .fault_code  (fault_code),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: phase plus countdown of cycles left, queue for the slot
    int         m_phase, m_left;
    logic [1:0] m_job, m_code;
    bit         m_drop, m_coin, m_retried, m_ov;
    logic [1:0] m_pend[$];

    int t_motor, t_hop, t_done, t_first_motor, t_first_hop, t_first_done, t_first_fault;
    int t_ov, t_code;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_vec();
        return {m_phase == P_MOTOR, m_phase == P_HOPPER, m_phase != P_IDLE,
                m_phase == P_DONE, m_phase == P_FAULT, m_code, m_ov};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {motor_on, hopper_on, busy, vend_done, fault, fault_code, overrun};
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_left = 0; m_job = 2'b00; m_code = 2'b00;
        m_drop = 0; m_coin = 0; m_retried = 0; m_ov = 0;
        m_pend.delete();
    endtask

    task automatic model_start(input logic [1:0] c);
        m_job = c; m_drop = 0; m_coin = 0;
        if (c[1]) begin m_phase = P_MOTOR;  m_left = MOTOR_CYCLES;  end
        else      begin m_phase = P_HOPPER; m_left = HOPPER_CYCLES; end
    endtask

    task automatic model_step(input logic [1:0] c, input logic i, input logic co, input logic fc);
        bit         req = (c != 2'b00);
        logic [1:0] nxt = 2'b00;
        int         ph  = m_phase;
        if (ph == P_FAULT) m_pend.delete();
        else if ((ph == P_IDLE || ph == P_DONE) && m_pend.size() != 0) begin
            nxt = m_pend.pop_front();
            if (req) m_pend.push_back(c);
        end else if (ph == P_IDLE) nxt = c;
        else if (req) begin
            if (m_pend.size() == 0) m_pend.push_back(c);
            else m_ov = 1;
        end
        case (ph)
            P_IDLE, P_DONE: begin
                if (ph == P_DONE) m_retried = 0;
                if (nxt != 2'b00) model_start(nxt);
                else m_phase = P_IDLE;
            end
            P_MOTOR: begin
                if (i) m_drop = 1;
                m_left--;
                if (m_left == 0) begin m_phase = P_WDROP; m_left = DROP_TIMEOUT; end
            end
            P_WDROP: begin
                if (m_drop || i) begin
                    if (m_job[0]) begin m_phase = P_HOPPER; m_left = HOPPER_CYCLES; m_coin = 0; end
                    else m_phase = P_DONE;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        if (RETRY && !m_retried) begin
                            m_retried = 1; m_phase = P_MOTOR; m_left = MOTOR_CYCLES;
                        end else begin
                            m_phase = P_FAULT; m_code = 2'b01;
                        end
                    end
                end
            end
            P_HOPPER: begin
                if (co) m_coin = 1;
                m_left--;
                if (m_left == 0) begin m_phase = P_WCOIN; m_left = COIN_TIMEOUT; end
            end
            P_WCOIN: begin
                if (m_coin || co) m_phase = P_DONE;
                else begin
                    m_left--;
                    if (m_left == 0) begin m_phase = P_FAULT; m_code = 2'b10; end
                end
            end
            default: begin
                m_retried = 0;
                if (fc) begin m_phase = P_IDLE; m_code = 2'b00; m_ov = 0; end
            end
        endcase
    endtask

    task automatic tick(input logic [1:0] c, input logic i, input logic co, input logic fc);
        cmd = c; item_sensed = i; coin_sensed = co; fault_clr = fc;
        model_step(c, i, co, fc);
        @(negedge clk);
        check("outputs", 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic apply_reset();
        #2;
        rst = 1'b1; cmd = 2'b00; item_sensed = 1'b0; coin_sensed = 1'b0; fault_clr = 1'b0;
        #1;
        check("async_reset", 32'(dut_vec()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("reset_state", 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic clear_obs();
        t_motor = 0; t_hop = 0; t_done = 0;
        t_first_motor = -1; t_first_hop = -1; t_first_done = -1; t_first_fault = -1;
        t_ov = -1; t_code = -1;
    endtask

    task automatic observe(input int cyc);
        if (motor_on)  begin t_motor++; if (t_first_motor < 0) t_first_motor = cyc; end
        if (hopper_on) begin t_hop++;   if (t_first_hop < 0)   t_first_hop = cyc;   end
        if (vend_done) begin t_done++;  if (t_first_done < 0)  t_first_done = cyc;  end
        if (fault && t_first_fault < 0) t_first_fault = cyc;
    endtask

    initial begin
        apply_reset();

        // Product only, drop in WAIT_DROP
        clear_obs();
        for (int cyc = 0; cyc <= 15; cyc++) begin
            tick(cyc == 0 ? 2'b10 : 2'b00, cyc == 12, 1'b0, 1'b0);
            observe(cyc + 1);
            if (cyc + 1 == 14) t_ov = int'(busy);
        end
        check("t1_first_motor", 32'(t_first_motor), 32'd1);
        check("t1_motor_cycles", 32'(t_motor), 32'd8);
        check("t1_done_cycle", 32'(t_first_done), 32'd13);
        check("t1_busy_at_14", 32'(t_ov), 32'd0);

        // Product + change
        apply_reset();
        clear_obs();
        for (int cyc = 0; cyc <= 21; cyc++) begin
            tick(cyc == 0 ? 2'b11 : 2'b00, cyc == 10, cyc == 17, 1'b0);
            observe(cyc + 1);
        end
        check("t2_first_hopper", 32'(t_first_hop), 32'd11);
        check("t2_hopper_cycles", 32'(t_hop), 32'd4);
        check("t2_done_count", 32'(t_done), 32'd1);
        check("t2_done_cycle", 32'(t_first_done), 32'd18);

        // No drop: timeout (and optional retry)
        apply_reset();
        clear_obs();
        for (int cyc = 0; cyc <= (RETRY ? 90 : 50); cyc++) begin
            tick(cyc == 0 ? 2'b10 : 2'b00, 1'b0, 1'b0, 1'b0);
            observe(cyc + 1);
        end
        check("t3_fault_cycle", 32'(t_first_fault), RETRY ? 32'd81 : 32'd41);
        check("t3_motor_cycles", 32'(t_motor), RETRY ? 32'd16 : 32'd8);
        check("t3_fault_code", 32'(fault_code), 32'd1);

        // Queued change command and a lost one
        apply_reset();
        clear_obs();
        for (int cyc = 0; cyc <= 22; cyc++) begin
            tick(cyc == 0 ? 2'b10 : (cyc == 3 ? 2'b01 : (cyc == 5 ? 2'b11 : 2'b00)),
                 cyc == 12, cyc == 18, 1'b0);
            observe(cyc + 1);
            if (cyc + 1 == 4) t_ov = int'(overrun);
        end
        check("t4_overrun_after_store", 32'(t_ov), 32'd0);
        check("t4_overrun_final", 32'(overrun), 32'd1);
        check("t4_motor_cycles", 32'(t_motor), 32'd8);
        check("t4_first_hopper", 32'(t_first_hop), 32'd14);
        check("t4_done_count", 32'(t_done), 32'd2);

        // Coin timeout, ignored cmd in FAULT, fault_clr
        apply_reset();
        clear_obs();
        for (int cyc = 0; cyc <= 28; cyc++) begin
            tick(cyc == 0 ? 2'b01 : (cyc == 22 ? 2'b10 : 2'b00), 1'b0, 1'b0, cyc == 24);
            observe(cyc + 1);
            if (cyc + 1 == 23) begin t_ov = int'(overrun); t_code = int'(fault_code); end
        end
        check("t5_fault_cycle", 32'(t_first_fault), 32'd21);
        check("t5_code_in_fault", 32'(t_code), 32'd2);
        check("t5_no_overrun", 32'(t_ov), 32'd0);
        check("t5_motor_cycles", 32'(t_motor), 32'd0);
        check("t5_after_clear", 32'(dut_vec()), 32'd0);

        // Reset mid-MOTOR with a command waiting in the slot
        apply_reset();
        for (int cyc = 0; cyc <= 3; cyc++)
            tick(cyc == 0 ? 2'b10 : (cyc == 2 ? 2'b01 : 2'b00), 1'b0, 1'b0, 1'b0);
        check("t6_motor_before_rst", 32'(motor_on), 32'd1);
        apply_reset();
        clear_obs();
        for (int cyc = 0; cyc <= 20; cyc++) begin
            tick(2'b00, 1'b0, 1'b0, 1'b0);
            observe(cyc + 1);
        end
        check("t6_no_motor_after_rst", 32'(t_motor), 32'd0);
        check("t6_no_hopper_after_rst", 32'(t_hop), 32'd0);

        // Random traffic
        apply_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 799) == 0) begin
                apply_reset();
            end else begin
                tick(($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                     $urandom_range(0, 29) == 0,
                     $urandom_range(0, 14) == 0,
                     $urandom_range(0, 7) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
